// File: rtl/row_render_pkg.sv
// row_render_pkg: shared line-renderer geometry, region codes and colours.
package row_render_pkg;
   localparam int H_VIEW_DEF   = 640;
   localparam int H_CENTER_DEF = 320;
   localparam int TEX_H_DEF    = 64;
   localparam int HPOS_W       = 10;
   localparam int SIZE_W       = 11;
   localparam int ACC_W        = 12;
   localparam int TEXV_W       = 6;
   localparam logic [1:0] REG_BLANK = 2'd0;
   localparam logic [1:0] REG_CEIL  = 2'd1;
   localparam logic [1:0] REG_WALL  = 2'd2;
   localparam logic [1:0] REG_FLOOR = 2'd3;
   localparam logic [5:0] RGB_BLANK  = 6'b000000;
   localparam logic [5:0] RGB_CEIL   = 6'b010101;
   localparam logic [5:0] RGB_FLOOR  = 6'b101010;
   localparam logic [5:0] RGB_WALL_X = 6'b000011;
   localparam logic [5:0] RGB_WALL_Y = 6'b000010;
   // Wall shade comes from the top texel bits; Y faces are drawn darker.
   function automatic logic [5:0] wall_rgb(input logic [1:0] vh, input logic side);
      return side ? (RGB_WALL_Y | {1'b0, vh[1], 1'b0, vh[1], 2'b00})
                  : (RGB_WALL_X | {vh, vh, 2'b00});
   endfunction
endpackage

// File: rtl/row_render_tex_stepper.sv
// tex_stepper: Bresenham texel stepper; v is the texel index after this cycle's load/step.
module tex_stepper
   import row_render_pkg::*;
#(
   parameter int TEX_H = TEX_H_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              step,
   input  logic [SIZE_W-1:0] d,
   output logic [TEXV_W-1:0] v
);
   localparam logic [ACC_W-1:0]  STEP  = ACC_W'(TEX_H);
   localparam logic [TEXV_W-1:0] V_MAX = TEXV_W'(TEX_H - 1);
   logic [ACC_W-1:0]  acc_q, acc_d, sum, dd;
   logic [TEXV_W-1:0] v_q, v_d;
   logic              over;
   // d >= TEX_H, so a single subtraction per step keeps acc below d.
   always_comb begin
      dd    = ACC_W'(d);
      sum   = acc_q + STEP;
      over  = sum >= dd;
      acc_d = load ? '0 : step ? (over ? sum - dd : sum) : acc_q;
      v_d   = load ? '0 : (step && over && v_q != V_MAX) ? v_q + TEXV_W'(1) : v_q;
      v     = v_d;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         v_q   <= '0;
      end else begin
         acc_q <= acc_d;
         v_q   <= v_d;
      end
   end
endmodule

// File: rtl/row_render.sv
// row_render: turns one traced wall slice per line into region, texel and colour per pixel.
module row_render
   import row_render_pkg::*;
#(
   parameter int H_VIEW   = H_VIEW_DEF,
   parameter int H_CENTER = H_CENTER_DEF,
   parameter int TEX_H    = TEX_H_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              hmax,
   input  logic [HPOS_W-1:0] hpos,
   input  logic              i_side,
   input  logic [SIZE_W-1:0] i_size,
   output logic [1:0]        o_region,
   output logic [TEXV_W-1:0] o_tex_v,
   output logic [5:0]        o_rgb
);
   localparam logic [SIZE_W-1:0] CTR  = SIZE_W'(H_CENTER);
   localparam logic [SIZE_W-1:0] VIEW = SIZE_W'(H_VIEW);
   localparam logic [SIZE_W-1:0] TEXH = SIZE_W'(TEX_H);
   logic              hmax_q;
   logic              pend_side_q, pend_side_d, act_side_q, act_side_d;
   logic [SIZE_W-1:0] pend_half_q, pend_half_d, act_half_q, act_half_d;
   logic [SIZE_W-1:0] hp, wall_start, wall_end, twice, d;
   logic [1:0]        region_q, region_d;
   logic [TEXV_W-1:0] tex_v_q, tex_v_d, v;
   logic [5:0]        rgb_q, rgb_d;
   logic              load, step;
   // Captures land in the pending buffer; the line buffer only swaps at hpos 0,
   // with a bypass so a capture on hpos 0 itself drives that same line.
   always_comb begin
      pend_half_d = hmax_q ? (i_size > CTR ? CTR : i_size) : pend_half_q;
      pend_side_d = hmax_q ? i_side : pend_side_q;
      act_half_d  = (hpos == '0) ? pend_half_d : act_half_q;
      act_side_d  = (hpos == '0) ? pend_side_d : act_side_q;
      hp          = SIZE_W'(hpos);
      wall_start  = CTR - act_half_d;
      wall_end    = CTR + act_half_d;
      twice       = act_half_d + act_half_d;
      d           = twice > TEXH ? twice : TEXH;
      region_d    = hp >= VIEW ? REG_BLANK : hp < wall_start ? REG_CEIL :
                    hp < wall_end ? REG_WALL : REG_FLOOR;
      load        = hp == wall_start;
      step        = region_d == REG_WALL && !load;
      tex_v_d     = region_d == REG_WALL ? v : '0;
      rgb_d       = region_d == REG_WALL  ? wall_rgb(v[5:4], act_side_d) :
                    region_d == REG_CEIL  ? RGB_CEIL :
                    region_d == REG_FLOOR ? RGB_FLOOR : RGB_BLANK;
   end
   tex_stepper #(.TEX_H(TEX_H)) u_step (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .step    (step),
      .d       (d),
      .v       (v)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hmax_q      <= 1'b0;
         pend_half_q <= '0;
         pend_side_q <= 1'b0;
         act_half_q  <= '0;
         act_side_q  <= 1'b0;
         region_q    <= REG_BLANK;
         tex_v_q     <= '0;
         rgb_q       <= RGB_BLANK;
      end else begin
         hmax_q      <= hmax;
         pend_half_q <= pend_half_d;
         pend_side_q <= pend_side_d;
         act_half_q  <= act_half_d;
         act_side_q  <= act_side_d;
         region_q    <= region_d;
         tex_v_q     <= tex_v_d;
         rgb_q       <= rgb_d;
      end
   end
   assign o_region = region_q;
   assign o_tex_v  = tex_v_q;
   assign o_rgb    = rgb_q;
endmodule

// File: tb/tb_row_render.sv
// tb_row_render: random and directed lines checked against a per-pixel reference model.
module tb_row_render;
   logic        clk = 1'b0, reset_n = 1'b0, hmax = 1'b0, i_side = 1'b0;
   logic [9:0]  hpos = '0;
   logic [10:0] i_size = '0;
   logic [1:0]  o_region;
   logic [5:0]  o_tex_v, o_rgb;
   int n_vec = 0, n_bad = 0;
   int pin_reg[800], pin_tv[800], pin_rgb[800];
   int st_reg[800], st_tv[800], st_rgb[800];
   int m_pend_h, m_pend_s, m_act_h, m_act_s, m_prev;
   int e_reg, e_tv, e_rgb, hs, ws, we, dv;

   row_render dut (
      .clk(clk), .reset_n(reset_n), .hmax(hmax), .hpos(hpos), .i_side(i_side),
      .i_size(i_size), .o_region(o_region), .o_tex_v(o_tex_v), .o_rgb(o_rgb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s hpos=%0d got %0d expected %0d at %0t", name, hs, act, exp, $time);
      end
   endtask

   function automatic int colour(input int r, input int v, input int s);
      if (r == 0) return 0;
      if (r == 1) return 21;
      if (r == 3) return 42;
      return s != 0 ? ((v >> 5) & 1) * 20 + 2 : ((v >> 4) & 3) * 20 + 3;
   endfunction

   // Reference: region from the line's bounds, texel = floor(k*TEX_H/D) saturated.
   always @(posedge clk) begin
      hs = int'(hpos);
      if (!reset_n) begin
         m_pend_h = 0; m_pend_s = 0; m_act_h = 0; m_act_s = 0; m_prev = 0;
         e_reg = 0; e_tv = 0; e_rgb = 0;
      end else begin
         if (m_prev != 0) begin
            m_pend_h = int'(i_size) > 320 ? 320 : int'(i_size);
            m_pend_s = int'(i_side);
         end
         m_prev = int'(hmax);
         if (hs == 0) begin
            m_act_h = m_pend_h;
            m_act_s = m_pend_s;
         end
         ws = 320 - m_act_h;
         we = 320 + m_act_h;
         dv = 2 * m_act_h > 64 ? 2 * m_act_h : 64;
         e_reg = hs >= 640 ? 0 : hs < ws ? 1 : hs < we ? 2 : 3;
         e_tv  = 0;
         if (e_reg == 2) begin
            e_tv = (hs - ws) * 64 / dv;
            if (e_tv > 63) e_tv = 63;
         end
         e_rgb = colour(e_reg, e_tv, m_act_s);
      end
      #1;
      chk("region", int'(o_region), e_reg);
      chk("tex_v", int'(o_tex_v), e_tv);
      chk("rgb", int'(o_rgb), e_rgb);
      if (pin_reg[hs] >= 0) chk("pin_region", int'(o_region), pin_reg[hs]);
      if (pin_tv[hs] >= 0) chk("pin_tex_v", int'(o_tex_v), pin_tv[hs]);
      if (pin_rgb[hs] >= 0) chk("pin_rgb", int'(o_rgb), pin_rgb[hs]);
   end

   task automatic run_line(input int size, input int side, input int mid, input int mid_size,
                           input int end_hmax, input int rst_h);
      for (int h = 0; h < 800; h++) begin
         @(negedge clk);
         if (h == 0) begin
            for (int j = 0; j < 800; j++) begin
               pin_reg[j] = st_reg[j]; pin_tv[j] = st_tv[j]; pin_rgb[j] = st_rgb[j];
               st_reg[j] = -1; st_tv[j] = -1; st_rgb[j] = -1;
            end
            i_size = 11'(size);
            i_side = side[0];
         end
         hpos = 10'(h);
         hmax = (h == 799 && end_hmax != 0) || h == mid;
         if (h == mid) begin
            i_size = 11'(mid_size);
            i_side = ~i_side;
         end
         if (h == rst_h) begin
            #2 reset_n = 1'b0;
            #1;
            chk("reset_region", int'(o_region), 0);
            chk("reset_tex_v", int'(o_tex_v), 0);
            chk("reset_rgb", int'(o_rgb), 0);
         end
         if (h == rst_h + 5) reset_n = 1'b1;
      end
   endtask

   initial begin
      for (int j = 0; j < 800; j++) begin
         pin_reg[j] = -1; pin_tv[j] = -1; pin_rgb[j] = -1;
         st_reg[j] = -1; st_tv[j] = -1; st_rgb[j] = -1;
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      st_reg[0] = 1; st_reg[319] = 1; st_reg[320] = 3; st_reg[639] = 3; st_reg[640] = 0; st_tv[320] = 0;
      run_line(100, 0, -1, 0, 1, -1);
      st_reg[219] = 1; st_reg[220] = 2; st_reg[419] = 2; st_reg[420] = 3; st_reg[640] = 0;
      st_tv[220] = 0; st_tv[419] = 63; st_rgb[220] = 3;
      run_line(100, 0, -1, 0, 1, -1);
      st_tv[288] = 0; st_tv[289] = 1; st_tv[351] = 63; st_reg[351] = 2; st_reg[352] = 3;
      run_line(32, 0, -1, 0, 1, -1);
      st_reg[0] = 2; st_tv[0] = 0; st_reg[639] = 2; st_tv[639] = 63; st_rgb[639] = 63; st_reg[640] = 0;
      run_line(700, 0, -1, 0, 1, -1);
      st_reg[319] = 1; st_reg[320] = 3; st_tv[320] = 0;
      run_line(0, 0, -1, 0, 1, -1);
      st_reg[309] = 1; st_reg[310] = 2; st_tv[310] = 0; st_reg[329] = 2; st_tv[329] = 19;
      st_rgb[329] = 2; st_reg[330] = 3;
      run_line(10, 1, -1, 0, 1, -1);
      st_reg[420] = 3; st_reg[419] = 2;
      run_line(100, 0, 400, 50, 0, -1);
      st_reg[269] = 1; st_reg[270] = 2; st_reg[370] = 3;
      run_line(200, 0, -1, 0, 1, -1);
      st_reg[299] = 2; st_reg[310] = 1; st_reg[330] = 3;
      run_line(100, 0, -1, 0, 1, 300);
      st_reg[220] = 2; st_rgb[219] = 21;
      run_line(100, 1, -1, 0, 1, -1);
      repeat (10) begin
         run_line($urandom_range(0, 1) != 0 ? $urandom_range(0, 40) : $urandom_range(0, 800),
                  $urandom_range(0, 1),
                  $urandom_range(0, 3) == 0 ? $urandom_range(0, 639) : -1,
                  $urandom_range(0, 800), $urandom_range(0, 4) != 0 ? 1 : 0, -1);
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
